fixed_expand_loader: RTL

Streaming reader that fetches `count` DATA_BITS fixed-point words from a synchronous-read buffer memory. It converts each word to the INTERNAL_BITS accumulator format and delivers it on a valid/ready stream. Conversion is the exact inverse of the accumulator-to-data truncation: the word is sign-extended and shifted left by FRAC_BITS. The block sits between the feature-map/weight buffer and the MAC datapath, and is used to preload partial sums or bias values into accumulators.

---
 rtl/fixed_expand_loader.sv | 125 ++++++++++++
 1 files changed

// File: rtl/fixed_expand_loader.sv
// rtl/fixed_expand_loader.sv - buffer-memory reader that expands fixed-point words to accumulator format
module fixed_expand_loader #(
    parameter int DATA_BITS     = 16,
    parameter int INTERNAL_BITS = 32,
    parameter int FRAC_BITS     = 8,
    parameter int ADDR_BITS     = 12
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [ADDR_BITS-1:0]     base_addr,
    input  logic [ADDR_BITS-1:0]     count,
    output logic                     busy,
    output logic                     done,
    output logic                     mem_rd_en,
    output logic [ADDR_BITS-1:0]     mem_addr,
    input  logic [DATA_BITS-1:0]     mem_rdata,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [INTERNAL_BITS-1:0] out_data,
    output logic                     out_last
);

    localparam int EXT_BITS = INTERNAL_BITS - DATA_BITS - FRAC_BITS;
    localparam int CW       = ADDR_BITS + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                 state_q, state_d;
    logic [ADDR_BITS-1:0]   base_q, base_d;
    logic [ADDR_BITS-1:0]   count_q, count_d;
    logic [ADDR_BITS-1:0]   issued_q, issued_d;
    logic [ADDR_BITS-1:0]   accepted_q, accepted_d;
    logic                   inflight_q, inflight_d;
    logic                   infl_last_q, infl_last_d;
    logic [1:0]             occ_q, occ_d;
    logic                   wr_ptr_q, rd_ptr_q;
    logic [INTERNAL_BITS-1:0] fifo_data_q [0:1];
    logic                   fifo_last_q [0:1];

    logic                   pop, push, rd_en;
    logic [INTERNAL_BITS-1:0] expanded;

    assign expanded = {{EXT_BITS{mem_rdata[DATA_BITS-1]}}, mem_rdata, {FRAC_BITS{1'b0}}};
    assign pop      = out_valid & out_ready;
    // The read issued last cycle always lands in the FIFO, so it is counted as occupied space.
    assign push     = inflight_q;
    assign rd_en    = (state_q == RUN) && (issued_q < count_q) &&
                      (({1'b0, occ_q} + {2'b0, inflight_q}) < (3'd2 + {2'b0, pop}));

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        count_d     = count_q;
        issued_d    = issued_q;
        accepted_d  = accepted_q;
        inflight_d  = rd_en;
        infl_last_d = (issued_q == (count_q - ADDR_BITS'(1)));
        occ_d       = occ_q + {1'b0, push} - {1'b0, pop};
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = RUN;
                    base_d     = base_addr;
                    count_d    = count;
                    issued_d   = '0;
                    accepted_d = '0;
                end
            end
            RUN: begin
                if (issued_q == count_q) state_d = DRAIN;
            end
            DRAIN: begin
                if (({1'b0, accepted_q} + CW'(pop)) == {1'b0, count_q}) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (rd_en) issued_d = issued_q + ADDR_BITS'(1);
        if (pop)   accepted_d = accepted_q + ADDR_BITS'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            base_q      <= '0;
            count_q     <= '0;
            issued_q    <= '0;
            accepted_q  <= '0;
            inflight_q  <= 1'b0;
            infl_last_q <= 1'b0;
            occ_q       <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                fifo_data_q[i] <= '0;
                fifo_last_q[i] <= 1'b0;
            end
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            count_q     <= count_d;
            issued_q    <= issued_d;
            accepted_q  <= accepted_d;
            inflight_q  <= inflight_d;
            infl_last_q <= infl_last_d;
            occ_q       <= occ_d;
            if (push) begin
                fifo_data_q[wr_ptr_q] <= expanded;
                fifo_last_q[wr_ptr_q] <= infl_last_q;
                wr_ptr_q              <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
        end
    end

    assign busy      = (state_q == RUN) || (state_q == DRAIN);
    assign done      = (state_q == DONE);
    assign mem_rd_en = rd_en;
    assign mem_addr  = base_q + issued_q;
    assign out_valid = (occ_q != 2'd0);
    assign out_data  = out_valid ? fifo_data_q[rd_ptr_q] : '0;
    assign out_last  = out_valid & fifo_last_q[rd_ptr_q];

endmodule
